// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter: the sequencer state
//   encoding and the default start-timeout budget.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int DEFAULT_START_TIMEOUT = 16;

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// rr_priority_picker
//   Combinational round-robin selector. Finds the first set request bit
//   strictly after last_gnt, wrapping modulo NUM_REQ.
//   Ports:
//     req      in   NUM_REQ  request levels
//     last_gnt in   IDX_W    index of the previous winner
//     pick     out  NUM_REQ  one-hot winner (zero when no request)
//     pick_idx out  IDX_W    index of the winner
//     any      out  1        at least one request present
module rr_priority_picker #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_gnt,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_masked;

  // The request vector is duplicated so that the wrap-around search becomes
  // a plain lowest-bit priority encode; everything at or below last_gnt in
  // the lower copy is masked, and the upper copy supplies the wrapped bits.
  always_comb begin
    req_dbl    = {req, req};
    req_masked = '0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      req_masked[i] = req_dbl[i] && (i > int'(last_gnt));
    end
  end

  always_comb begin
    logic found;
    found    = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (req_masked[i] && !found) begin
        found    = 1'b1;
        pick_idx = IDX_W'(i % NUM_REQ);
      end
    end
  end

  assign any  = |req;
  assign pick = any ? (NUM_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_tx_core between NUM_REQ byte producers. Grants one
//   requester at a time (round robin), launches its byte with a toggle on
//   tx_start, follows the core's busy to completion and pulses done back to
//   the winner. A watchdog aborts the transaction if busy never rises.
//   Ports:
//     clk, reset_n  clock, asynchronous active-low reset
//     req           in   NUM_REQ         request levels, held until done
//     req_data      in   NUM_REQ*DATA_W  byte of requester i at [i*DATA_W +: DATA_W]
//     gnt           out  NUM_REQ         one-hot grant for the whole transaction
//     done          out  NUM_REQ         one-cycle completion/abort pulse
//     tx_start      out  1               toggles once per launched byte
//     tx_data       out  DATA_W          latched byte for the core
//     tx_busy       in   1               core busy
//     timeout_err   out  1               sticky start-timeout flag
//     clear_err     in   1               synchronous clear of timeout_err
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic                      timeout_err,
  input  logic                      clear_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(START_TIMEOUT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  arb_state_t           state_q, state_d;
  logic [IDX_W-1:0]     last_gnt_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 any;
  logic                 grant, launch, finish, abort;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req      (req),
    .last_gnt (last_gnt_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    launch  = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          grant   = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        launch  = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = sat_inc(cnt_q);
          // No retry on timeout: the requester gets done and must decide.
          if (cnt_d == TIMEOUT_VAL) begin
            abort   = 1'b1;
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt         <= '0;
      done        <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      timeout_err <= 1'b0;
      cnt_q       <= '0;
      last_gnt_q  <= IDX_W'(NUM_REQ - 1);
    end else begin
      cnt_q <= cnt_d;
      done  <= finish ? gnt : '0;
      if (grant) begin
        gnt        <= pick;
        last_gnt_q <= pick_idx;
        tx_data    <= req_data[pick_idx*DATA_W +: DATA_W];
      end else if (finish) begin
        gnt <= '0;
      end
      if (launch) tx_start <= ~tx_start;
      // A timeout in the same cycle as clear_err wins, so no abort is lost.
      if (abort)          timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx_core` between up to `NUM_REQ` byte producers (classifier result reporter, debug dumper, status beacon). It grants the transmitter to one requester at a time, launches the byte with the toggle-style start that `uart_tx_core` expects, tracks the core's `busy` to completion and returns a per-requester done pulse. A start-timeout watchdog flags a core that never goes busy.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DATA_W`, 8: byte width, equal to the core's `NO_OF_DATABITS`
- `START_TIMEOUT`, 16: cycles allowed between launch and `tx_busy` rising
- `clk`  in  1  system clock, 100 MHz
- `reset_n`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester request level; held with its data until `done`
- `req_data`  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- `gnt`  out  NUM_REQ  one-hot grant, high for the whole transaction
- `done`  out  NUM_REQ  one-cycle pulse to the granted requester at completion or abort
- `tx_start`  out  1  toggles once per launched byte; drives the core's `start_transmission`
- `tx_data`  out  DATA_W  registered byte to the core's `data_in`, stable for the whole transaction
- `tx_busy`  in  1  the core's `busy`
- `timeout_err`  out  1  sticky; set on start timeout
- `clear_err`  in  1  synchronous clear of `timeout_err`

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE: if any `req` bit is set, pick the first set bit starting at `last_gnt+1` and wrapping modulo `NUM_REQ`. Register `gnt`, latch `tx_data` from that slice, update `last_gnt`, go to LAUNCH.
- LAUNCH, one cycle: invert `tx_start`, clear the timeout counter, go to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_busy`=1: go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `START_TIMEOUT`, set `timeout_err`, pulse `done`, clear `gnt` and go to IDLE. This is an abort; there is no retry.
- WAIT_DONE: on `tx_busy`=0, pulse `done`, clear `gnt` and go to IDLE.
- Requests:
  - `req` deassertion while granted is ignored, and the transaction runs to completion.
  - `req_data` changes after LAUNCH have no effect.
- Errors: `clear_err` and a new timeout in the same cycle leave `timeout_err` set.
- Counter width is `$clog2(START_TIMEOUT+1)`, and it saturates.

## Timing
- Reset values: `gnt`=0, `done`=0, `tx_start`=0, `tx_data`=0, `timeout_err`=0, `last_gnt`=`NUM_REQ-1` (first arbitration favours requester 0), state IDLE.
- `req` sampled high at edge k: `gnt` rises at edge k+1 (LAUNCH) and `tx_start` toggles at edge k+2.
- The core raises `busy` about 2 cycles after the toggle.
- `done` is asserted in the cycle after `tx_busy` is sampled low. `gnt` falls on that same edge.
- At least one IDLE cycle separates consecutive transactions. Back-to-back grants to different requesters are therefore ≥3 cycles plus the frame time apart.
- Reset mid-operation:
  - All outputs return to their reset values immediately.
  - The core is reset by the same reset tree, so the `tx_start` edge caused by reset is absorbed while the core is in reset.
  - Requesters must treat reset as cancelling their transaction; no `done` is issued.
- If `tx_busy` is already high on entering WAIT_BUSY, the block advances on the next edge.

## Structure
- Shared package or include `uart_arb_defs.vh`:
  - 2-bit state encodings: IDLE=0, LAUNCH=1, WAIT_BUSY=2, WAIT_DONE=3.
  - Default `START_TIMEOUT`.
- Sub-module `rr_priority_picker`:
  - Combinational.
  - Inputs: `req`, `last_gnt`.
  - Outputs: one-hot `pick`, index `pick_idx`, `any`.
  - Implemented as a double-width masked priority encoder.
- Top: FSM, data latch, toggle register, timeout counter, error flag.

## Test plan
- Single request: `req`=0001 with data 0x41 and a core model raising busy 2 cycles after the toggle and holding it 10 cycles → `gnt`=0001 one cycle after `req`, `tx_data`=0x41, one `tx_start` toggle, one `done`[0] pulse after busy falls.
- Fairness: `req`=1111 held continuously, data 0x10..0x13 → grant order 0,1,2,3,0 with matching `tx_data`, and exactly one toggle per grant.
- Wrap-around: `last_gnt`=3 and `req`=1010 → requester 1 wins, then requester 3.
- Timeout: the core model never raises busy → `done` pulses 16 cycles after the toggle, `timeout_err`=1 and the next request is still served. `clear_err` clears the flag, except when coincident with a new timeout, where it stays 1.
- Reset mid-frame: drop `reset_n` in WAIT_DONE → `gnt`/`done`/`tx_start`/`tx_data`=0 and no `done` pulse. After release, a pending `req`=0100 is granted with requester 0 priority reset.
